ft_recovery_sequencer: RTL and testbench

- Sequences rollback recovery for the lockstep core pair after a comparator mismatch.
- Recovery steps, in order:
  - halts both cores and waits for both to acknowledge;
  - copies the shadow register file into both cores' register files, one register per cycle;
  - restores the shadow PC;
  - resumes the cores.
- Tracks consecutive recoveries and escalates to a sticky fatal state on a storm of repeated errors or an unacknowledged halt.
- Sits between the comparator error signal, the shadow GPR/PC storage and the two cores' halt/writeback ports.

---
 rtl/ft_pkg.sv | 18 +
 rtl/ft_sat_counter.sv | 24 ++
 rtl/ft_recovery_sequencer.sv | 124 ++++++++++++
 tb/tb_ft_recovery_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared types and default constants for the lockstep rollback-recovery sequencer.
package ft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_COPY,
    ST_PC,
    ST_RESUME,
    ST_FATAL
  } ft_rec_state_e;

  localparam int FT_NUM_REGS     = 32;
  localparam int FT_MAX_RETRY    = 3;
  localparam int FT_RETRY_WINDOW = 256;
  localparam int FT_ACK_TIMEOUT  = 16;

endpackage

// File: rtl/ft_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment) and at-limit flag.
module ft_sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_lim_o
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                    cnt_o <= '0;
    else if (clr_i)                cnt_o <= '0;
    else if (inc_i && cnt_o != LIM) cnt_o <= cnt_o + 1'b1;
  end

  assign at_lim_o = (cnt_o == LIM);

endmodule

// File: rtl/ft_recovery_sequencer.sv
// Rollback recovery sequencer: halt both cores, restore GPRs and PC from shadow, resume.
// Define FT_ERR_COUNT_EN to make err_count_o a live saturating recovery counter.
module ft_recovery_sequencer
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = FT_NUM_REGS,
  parameter int MAX_RETRY    = FT_MAX_RETRY,
  parameter int RETRY_WINDOW = FT_RETRY_WINDOW,
  parameter int ACK_TIMEOUT  = FT_ACK_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  error_i,
  output logic                  halt_o,
  input  logic                  halt_ack_a_i,
  input  logic                  halt_ack_b_i,
  output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  input  logic [DATA_WIDTH-1:0] spc_i,
  output logic                  pc_we_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  resume_o,
  output logic                  busy_o,
  output logic                  fatal_o,
  output logic [7:0]            err_count_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int WW = $clog2(RETRY_WINDOW + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [RW-1:0]         MAX_R    = RW'(MAX_RETRY);

  ft_rec_state_e         state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [RW-1:0]         retry_cnt, retry_eff;
  logic [WW-1:0]         win_cnt;
  logic [AW-1:0]         ack_cnt;
  logic                  win_full, ack_lim, storm, start_rec;

  // A full window forgives past retries even on the very cycle it fills.
  assign retry_eff = win_full ? '0 : retry_cnt;
  assign storm     = (retry_eff == MAX_R);
  assign start_rec = (state == ST_IDLE) && error_i && !storm;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= ADDR_WIDTH'(1);
      retry_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_full) retry_cnt <= '0;
          if (error_i) begin
            if (storm) state <= ST_FATAL;
            else begin
              state     <= ST_HALT;
              retry_cnt <= retry_eff + 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (halt_ack_a_i && halt_ack_b_i) begin
            state <= ST_COPY;
            idx   <= ADDR_WIDTH'(1);
          end else if (ack_lim) begin
            state <= ST_FATAL;
          end
        end
        ST_COPY: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= ST_PC;
        end
        ST_PC:     state <= ST_RESUME;
        ST_RESUME: state <= ST_IDLE;
        ST_FATAL:  state <= ST_FATAL;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are pure state decodes; the write data path passes the shadow read straight through.
  assign halt_o       = (state == ST_HALT) || (state == ST_COPY) || (state == ST_PC) || (state == ST_FATAL);
  assign rf_we_o      = (state == ST_COPY);
  assign sgpr_raddr_o = rf_we_o ? idx : '0;
  assign rf_waddr_o   = rf_we_o ? idx : '0;
  assign rf_wdata_o   = rf_we_o ? sgpr_rdata_i : '0;
  assign pc_we_o      = (state == ST_PC);
  assign pc_o         = pc_we_o ? spc_i : '0;
  assign resume_o     = (state == ST_RESUME);
  assign busy_o       = (state != ST_IDLE) && (state != ST_FATAL);
  assign fatal_o      = (state == ST_FATAL);

  ft_sat_counter #(.WIDTH(WW), .LIMIT(RETRY_WINDOW)) u_win_cnt (
    .clk_i(clk_i), .rst_n(rst_n), .clr_i(start_rec), .inc_i(state == ST_IDLE),
    .cnt_o(win_cnt), .at_lim_o(win_full)
  );

  ft_sat_counter #(.WIDTH(AW), .LIMIT(ACK_TIMEOUT - 1)) u_ack_cnt (
    .clk_i(clk_i), .rst_n(rst_n), .clr_i(start_rec), .inc_i(state == ST_HALT),
    .cnt_o(ack_cnt), .at_lim_o(ack_lim)
  );

`ifdef FT_ERR_COUNT_EN
  logic err_full;
  ft_sat_counter #(.WIDTH(8), .LIMIT(255)) u_err_cnt (
    .clk_i(clk_i), .rst_n(rst_n), .clr_i(1'b0), .inc_i(start_rec),
    .cnt_o(err_count_o), .at_lim_o(err_full)
  );
  logic unused_cnt;
  assign unused_cnt = ^{win_cnt, ack_cnt, err_full};
`else
  assign err_count_o = '0;
  logic unused_cnt;
  assign unused_cnt = ^{win_cnt, ack_cnt};
`endif

endmodule

// File: tb/tb_ft_recovery_sequencer.sv
// Directed bench for ft_recovery_sequencer with immediate-assertion checks.
module tb_ft_recovery_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        error_i = 1'b0;
  logic        halt_ack_a_i = 1'b0;
  logic        halt_ack_b_i = 1'b0;
  logic        halt_o, rf_we_o, pc_we_o, resume_o, busy_o, fatal_o;
  logic [4:0]  sgpr_raddr_o, rf_waddr_o;
  logic [31:0] sgpr_rdata_i, rf_wdata_o, pc_o;
  logic [31:0] spc_i = 32'h0000_0400;
  logic [7:0]  err_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  assign sgpr_rdata_i = 32'h1000 + 32'(sgpr_raddr_o);

  ft_recovery_sequencer dut (
    .clk_i(clk_i), .rst_n(rst_n), .error_i(error_i), .halt_o(halt_o),
    .halt_ack_a_i(halt_ack_a_i), .halt_ack_b_i(halt_ack_b_i),
    .sgpr_raddr_o(sgpr_raddr_o), .sgpr_rdata_i(sgpr_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .spc_i(spc_i), .pc_we_o(pc_we_o), .pc_o(pc_o), .resume_o(resume_o),
    .busy_o(busy_o), .fatal_o(fatal_o), .err_count_o(err_count_o)
  );

  function automatic logic [31:0] ec(input int n);
`ifdef FT_ERR_COUNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {26'h0, halt_o, rf_we_o, pc_we_o, resume_o, busy_o, fatal_o}, 32'h0);
    chk({tag, "_addr"}, {14'h0, sgpr_raddr_o, rf_waddr_o, err_count_o}, 32'h0);
    chk({tag, "_data"}, rf_wdata_o | pc_o, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    error_i = 1'b0; halt_ack_a_i = 1'b0; halt_ack_b_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // One error pulse (or held error) and then follow the whole recovery, checking each write.
  task automatic recover(input int ack_dly, input bit hold, output int busy, output int wr,
                         output int pcw, output int rs);
    int exp_a;
    busy = 0; wr = 0; pcw = 0; rs = 0; exp_a = 1;
    error_i = 1'b1;
    step();
    if (!hold) error_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy_o) break;
      busy++;
      if (c == ack_dly) begin halt_ack_a_i = 1'b1; halt_ack_b_i = 1'b1; end
      if (rf_we_o) begin
        chk("wr_addr", {27'h0, rf_waddr_o}, 32'(exp_a));
        chk("wr_data", rf_wdata_o, 32'h1000 + 32'(exp_a));
        exp_a++;
        wr++;
      end
      if (pc_we_o) begin
        pcw++;
        chk("pc_val", pc_o, 32'h400);
      end
      if (resume_o) begin
        rs++;
        error_i = 1'b0;
      end
      step();
    end
    halt_ack_a_i = 1'b0; halt_ack_b_i = 1'b0; error_i = 1'b0;
  endtask

  initial begin
    int busy, wr, pcw, rs, n, bad;

    // Reset state
    #1;
    chk_zero("reset");
    do_reset();
    chk_zero("post_reset");

    // Basic recovery: HALT lasts 4 cycles, so busy = 4 + 31 + 1 + 1
    recover(3, 1'b0, busy, wr, pcw, rs);
    chk("basic_busy", 32'(busy), 32'd37);
    chk("basic_writes", 32'(wr), 32'd31);
    chk("basic_pcw", 32'(pcw), 32'd1);
    chk("basic_resume", 32'(rs), 32'd1);
    chk("basic_errcnt", {24'h0, err_count_o}, ec(1));
    chk_zero("basic_idle");

    // Immediate acks: shortest recovery is 34 busy cycles
    recover(0, 1'b0, busy, wr, pcw, rs);
    chk("fast_busy", 32'(busy), 32'd34);
    chk("fast_errcnt", {24'h0, err_count_o}, ec(2));

    // Ack timeout: only core A acknowledges
    do_reset();
    halt_ack_a_i = 1'b1;
    error_i = 1'b1;
    step();
    error_i = 1'b0;
    n = 0; bad = 0;
    while (!fatal_o && n < 40) begin
      if (rf_we_o) bad++;
      step();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_flags", {30'h0, halt_o, fatal_o}, 32'h3);
    repeat (5) begin
      if (rf_we_o) bad++;
      step();
    end
    chk("tmo_sticky", {30'h0, fatal_o, busy_o}, 32'h2);
    chk("tmo_no_wr", 32'(bad), 32'd0);
    halt_ack_a_i = 1'b0;
    do_reset();
    chk_zero("tmo_cleared");

    // Retry storm: three recoveries then FATAL
    for (int r = 0; r < 3; r++) begin
      recover(1, 1'b0, busy, wr, pcw, rs);
      chk("storm_resume", 32'(rs), 32'd1);
      repeat (10) step();
    end
    error_i = 1'b1;
    step();
    error_i = 1'b0;
    chk("storm_fatal", {29'h0, fatal_o, halt_o, busy_o}, 32'h6);
    chk("storm_errcnt", {24'h0, err_count_o}, ec(3));
    repeat (5) step();
    chk("storm_sticky", {29'h0, fatal_o, rf_we_o, resume_o}, 32'h4);

    // Window clear: 256+ idle cycles forgive earlier retries
    do_reset();
    for (int r = 0; r < 3; r++) begin
      recover(0, 1'b0, busy, wr, pcw, rs);
      repeat (10) step();
    end
    repeat (300) step();
    recover(0, 1'b0, busy, wr, pcw, rs);
    chk("win_writes", 32'(wr), 32'd31);
    chk("win_resume", 32'(rs), 32'd1);
    chk("win_fatal", {31'h0, fatal_o}, 32'h0);
    chk("win_errcnt", {24'h0, err_count_o}, ec(4));

    // Error held throughout recovery is ignored
    do_reset();
    recover(0, 1'b1, busy, wr, pcw, rs);
    chk("hold_writes", 32'(wr), 32'd31);
    chk("hold_resume", 32'(rs), 32'd1);
    repeat (3) step();
    chk("hold_idle", {30'h0, busy_o, fatal_o}, 32'h0);
    chk("hold_errcnt", {24'h0, err_count_o}, ec(1));

    // Reset in the middle of COPY
    do_reset();
    error_i = 1'b1;
    step();
    error_i = 1'b0;
    halt_ack_a_i = 1'b1; halt_ack_b_i = 1'b1;
    n = 0;
    while (!(rf_we_o && rf_waddr_o == 5'd10) && n < 60) begin
      step();
      n++;
    end
    chk("mid_reached_idx10", {31'h0, rf_we_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_async");
    halt_ack_a_i = 1'b0; halt_ack_b_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (resume_o || rf_we_o || busy_o) bad++;
      step();
    end
    chk("mid_quiet", 32'(bad), 32'd0);
    chk_zero("mid_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
